// File: rtl/xgmii_rx_measure.sv
// xgmii_rx_measure: XGMII RX frame delineation, length check, totals and per-second rates.
module xgmii_rx_measure #(
  parameter int CLK_FREQ = 156250000,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        rx_enable,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        frame_err,
  output logic [31:0] rx_frame_cnt,
  output logic [63:0] rx_byte_cnt,
  output logic [31:0] rx_err_cnt,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic        sec_tick
);
  typedef enum logic [1:0] {IDLE, PRE_HI, DATA} state_t;
  localparam logic [15:0] MIN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX16 = 16'(MAX_LEN);
  localparam logic [31:0] LAST = 32'(CLK_FREQ - 1);
  state_t state_q, state_d, start_st;
  logic [15:0] len_q, len_d, end_len, flen_q, flen_d;
  logic        bad_q, bad_d, done_q, done_d, ferr_q, ferr_d, tick_q, tick_d;
  logic [31:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d, pps_q, pps_d, thr_q, thr_d;
  logic [31:0] apkt_q, apkt_d, abyte_q, abyte_d, tmr_q, tmr_d, pkt_sum, byte_sum;
  logic [63:0] bcnt_q, bcnt_d;
  logic [32:0] byte_add;
  logic [2:0]  k;
  logic [7:0]  lane_k;
  logic        sol0, sol4, end_frame, aborted, end_err, good, badc, wrap;

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    k = 3'd0;
    for (int i = 7; i >= 0; i--) if (xgmii_rxc[i]) k = 3'(i);
    lane_k = xgmii_rxd[8*k +: 8];
    sol0 = xgmii_rxc == 8'h01 && xgmii_rxd[7:0] == 8'hFB;
    sol4 = xgmii_rxc == 8'h1F && xgmii_rxd[39:32] == 8'hFB;
    start_st = sol0 ? DATA : sol4 ? PRE_HI : IDLE;
    state_d = state_q;
    len_d = len_q;
    bad_d = bad_q;
    end_frame = 1'b0;
    end_len = len_q;
    aborted = bad_q;
    case (state_q)
      IDLE: begin
        state_d = start_st;
        len_d = 16'd0;
        bad_d = 1'b0;
      end
      PRE_HI: begin
        state_d = DATA;
        len_d = sat16(len_q, 4'd4);
        bad_d = |xgmii_rxc;
      end
      default: begin
        if (xgmii_rxc == 8'h00) begin
          len_d = sat16(len_q, 4'd8);
        end else if (lane_k == 8'hFD) begin
          end_frame = 1'b1;
          end_len = sat16(len_q, {1'b0, k});
          state_d = IDLE;
        end else begin
          // any other control aborts; a start in this word opens the next frame at once
          end_frame = 1'b1;
          aborted = 1'b1;
          state_d = start_st;
          len_d = 16'd0;
          bad_d = 1'b0;
        end
      end
    endcase
    end_err = aborted || end_len < MIN16 || end_len > MAX16;
    good = end_frame && !end_err && rx_enable;
    badc = end_frame && end_err && rx_enable;
    done_d = end_frame;
    flen_d = end_frame ? end_len : 16'd0;
    ferr_d = end_frame && end_err;
    fcnt_d = fcnt_q + 32'(good);
    bcnt_d = bcnt_q + (good ? 64'(end_len) : 64'd0);
    ecnt_d = ecnt_q + 32'(badc);
    wrap = tmr_q == LAST;
    tmr_d = wrap ? 32'd0 : tmr_q + 32'd1;
    pkt_sum = (good && apkt_q != '1) ? apkt_q + 32'd1 : apkt_q;
    byte_add = {1'b0, abyte_q} + (good ? 33'(end_len) : 33'd0);
    byte_sum = byte_add[32] ? '1 : byte_add[31:0];
    apkt_d = wrap ? 32'd0 : pkt_sum;
    abyte_d = wrap ? 32'd0 : byte_sum;
    pps_d = wrap ? pkt_sum : pps_q;
    thr_d = wrap ? byte_sum : thr_q;
    tick_d = wrap;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      len_q <= '0;
      bad_q <= 1'b0;
      done_q <= 1'b0;
      flen_q <= '0;
      ferr_q <= 1'b0;
      fcnt_q <= '0;
      bcnt_q <= '0;
      ecnt_q <= '0;
      tmr_q <= '0;
      apkt_q <= '0;
      abyte_q <= '0;
      pps_q <= '0;
      thr_q <= '0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      bad_q <= bad_d;
      done_q <= done_d;
      flen_q <= flen_d;
      ferr_q <= ferr_d;
      fcnt_q <= fcnt_d;
      bcnt_q <= bcnt_d;
      ecnt_q <= ecnt_d;
      tmr_q <= tmr_d;
      apkt_q <= apkt_d;
      abyte_q <= abyte_d;
      pps_q <= pps_d;
      thr_q <= thr_d;
      tick_q <= tick_d;
    end
  end

  assign frame_done = done_q;
  assign frame_len = flen_q;
  assign frame_err = ferr_q;
  assign rx_frame_cnt = fcnt_q;
  assign rx_byte_cnt = bcnt_q;
  assign rx_err_cnt = ecnt_q;
  assign rx_pps = pps_q;
  assign rx_throughput = thr_q;
  assign sec_tick = tick_q;
endmodule

// File: tb/tb_xgmii_rx_measure.sv
// tb_xgmii_rx_measure: directed frame table plus hand sequences for aborts, reset and rates.
module tb_xgmii_rx_measure;
  logic        sys_clk = 1'b0, sys_rst = 1'b1, rx_enable = 1'b1;
  logic [63:0] xgmii_rxd = {8{8'h07}};
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        frame_done, frame_err, sec_tick;
  logic [15:0] frame_len;
  logic [31:0] rx_frame_cnt, rx_err_cnt, rx_pps, rx_throughput;
  logic [63:0] rx_byte_cnt;
  int total = 0, bad = 0;
  logic [31:0] m_fcnt = 0, m_ecnt = 0;
  logic [63:0] m_bcnt = 0;
  localparam logic [63:0] IDLE_W = {8{8'h07}};
  localparam logic [63:0] SOF0_W = 64'hD5555555555555FB;
  localparam logic [63:0] SOF4_W = 64'h555555FB07070707;
  localparam logic [63:0] PREH_W = 64'h12345678D5555555;

  xgmii_rx_measure #(.CLK_FREQ(100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .rx_enable(rx_enable), .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err),
    .rx_frame_cnt(rx_frame_cnt), .rx_byte_cnt(rx_byte_cnt), .rx_err_cnt(rx_err_cnt),
    .rx_pps(rx_pps), .rx_throughput(rx_throughput), .sec_tick(sec_tick));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string name;
    logic  l4;
    int    nd;
    int    k;
    int    len;
    logic  err;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] c, input logic [63:0] d);
    xgmii_rxc = c;
    xgmii_rxd = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic term(input int k);
    logic [7:0]  c;
    logic [63:0] w;
    c = 8'hFF;
    c = c << k;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = i < k ? 8'hA5 : i == k ? 8'hFD : 8'h07;
    cyc(c, w);
  endtask

  task automatic data(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, {$urandom, $urandom});
  endtask

  task automatic expect_frame(input string name, input int len, input logic err);
    if (rx_enable && err) m_ecnt++;
    if (rx_enable && !err) begin
      m_fcnt++;
      m_bcnt += 64'(len);
    end
    chk({name, ".done"}, 64'(frame_done), 64'd1);
    chk({name, ".len"}, 64'(frame_len), 64'(len));
    chk({name, ".err"}, 64'(frame_err), 64'(err));
    chk({name, ".fcnt"}, 64'(rx_frame_cnt), 64'(m_fcnt));
    chk({name, ".bcnt"}, rx_byte_cnt, m_bcnt);
    chk({name, ".ecnt"}, 64'(rx_err_cnt), 64'(m_ecnt));
  endtask

  initial begin
    tv[0] = '{"runt60", 1'b0, 7, 4, 60, 1'b1};
    tv[1] = '{"good68", 1'b0, 8, 4, 68, 1'b0};
    tv[2] = '{"l4runt60", 1'b1, 7, 0, 60, 1'b1};
    tv[3] = '{"min64", 1'b0, 8, 0, 64, 1'b0};
    tv[4] = '{"min63", 1'b0, 7, 7, 63, 1'b1};
    tv[5] = '{"max1518", 1'b0, 189, 6, 1518, 1'b0};
    tv[6] = '{"max1519", 1'b0, 189, 7, 1519, 1'b1};
    tv[7] = '{"l4good72", 1'b1, 8, 4, 72, 1'b0};
    repeat (3) cyc(8'hFF, IDLE_W);
    chk("rst.done", 64'(frame_done), 64'd0);
    chk("rst.tick", 64'(sec_tick), 64'd0);
    sys_rst = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      cyc(8'hFF, IDLE_W);
      chk($sformatf("idle.tick%0d", i), 64'(sec_tick), 64'(i % 100 == 0));
      if (i % 100 == 0) begin
        chk("idle.pps", 64'(rx_pps), 64'd0);
        chk("idle.thr", 64'(rx_throughput), 64'd0);
      end
    end
    chk("idle.fcnt", 64'(rx_frame_cnt), 64'd0);
    chk("idle.ecnt", 64'(rx_err_cnt), 64'd0);
    chk("idle.bcnt", rx_byte_cnt, 64'd0);
    for (int v = 0; v < 8; v++) begin
      if (tv[v].l4) begin
        cyc(8'h1F, SOF4_W);
        cyc(8'h00, PREH_W);
      end else cyc(8'h01, SOF0_W);
      data(tv[v].nd);
      chk({tv[v].name, ".predone"}, 64'(frame_done), 64'd0);
      term(tv[v].k);
      expect_frame(tv[v].name, tv[v].len, tv[v].err);
      cyc(8'hFF, IDLE_W);
      chk({tv[v].name, ".pulse"}, 64'(frame_done), 64'd0);
    end
    cyc(8'h01, SOF0_W);
    data(3);
    cyc(8'h08, 64'h11111111FE222222);
    expect_frame("fe_abort", 24, 1'b1);
    cyc(8'hFF, IDLE_W);
    cyc(8'h01, SOF0_W);
    data(2);
    cyc(8'h01, SOF0_W);
    expect_frame("sof_abort", 16, 1'b1);
    data(8);
    term(0);
    expect_frame("sof_next", 64, 1'b0);
    cyc(8'h1F, SOF4_W);
    cyc(8'h80, 64'h0712345655555555);
    data(8);
    term(0);
    expect_frame("prehi_ctl", 68, 1'b1);
    rx_enable = 1'b0;
    cyc(8'h01, SOF0_W);
    data(8);
    term(4);
    expect_frame("disabled", 68, 1'b0);
    rx_enable = 1'b1;
    begin
      int n;
      n = 0;
      cyc(8'hFF, IDLE_W);
      while (!sec_tick && n < 200) begin
        cyc(8'hFF, IDLE_W);
        n++;
      end
      chk("wait_tick", 64'(sec_tick), 64'd1);
    end
    for (int f = 0; f < 10; f++) begin
      cyc(8'h01, SOF0_W);
      data(8);
      term(0);
      m_fcnt++;
      m_bcnt += 64;
    end
    chk("sec.done", 64'(frame_done), 64'd1);
    chk("sec.tick", 64'(sec_tick), 64'd1);
    chk("sec.pps", 64'(rx_pps), 64'd10);
    chk("sec.thr", 64'(rx_throughput), 64'd640);
    chk("sec.fcnt", 64'(rx_frame_cnt), 64'(m_fcnt));
    chk("sec.bcnt", rx_byte_cnt, m_bcnt);
    repeat (99) cyc(8'hFF, IDLE_W);
    chk("sec2.pretick", 64'(sec_tick), 64'd0);
    cyc(8'hFF, IDLE_W);
    chk("sec2.tick", 64'(sec_tick), 64'd1);
    chk("sec2.pps", 64'(rx_pps), 64'd0);
    chk("sec2.thr", 64'(rx_throughput), 64'd0);
    cyc(8'h01, SOF0_W);
    data(7);
    term(4);
    data(0);
    cyc(8'h01, SOF0_W);
    data(3);
    sys_rst = 1'b1;
    cyc(8'h00, {$urandom, $urandom});
    chk("mrst.done", 64'(frame_done), 64'd0);
    chk("mrst.len", 64'(frame_len), 64'd0);
    chk("mrst.err", 64'(frame_err), 64'd0);
    chk("mrst.fcnt", 64'(rx_frame_cnt), 64'd0);
    chk("mrst.bcnt", rx_byte_cnt, 64'd0);
    chk("mrst.ecnt", 64'(rx_err_cnt), 64'd0);
    chk("mrst.pps", 64'(rx_pps), 64'd0);
    chk("mrst.thr", 64'(rx_throughput), 64'd0);
    chk("mrst.tick", 64'(sec_tick), 64'd0);
    sys_rst = 1'b0;
    data(4);
    term(0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'hFF, IDLE_W);
      chk($sformatf("mrst.nodone%0d", i), 64'(frame_done), 64'd0);
    end
    chk("mrst.ecnt2", 64'(rx_err_cnt), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
